// File: rtl/rsa_byte_frontend_pkg.sv
// Shared types and widths for the RSA byte-stream front end.
package rsa_byte_frontend_pkg;

  localparam int RSA_W  = 128;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_t;

endpackage

// File: rtl/rsa_byte_frontend_if.sv
// Byte-link handshake bundle: input byte stream toward the core and
// output byte stream back to the host.
interface rsa_byte_frontend_if;
  import rsa_byte_frontend_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [BYTE_W-1:0] out_data;
  logic              out_ready;

  // Host side drives bytes in and accepts bytes out.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Front end side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/rsa_byte_frontend_shift.sv
// Byte-wide shift register: parallel load, or shift left by one byte
// inserting shift_in at the bottom. Load has priority over shift.
module rsa_shift_reg128 #(
  parameter int W = 128,
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic [B-1:0] shift_in,
  output logic [W-1:0] q
);

  // Register update: reset clears, load replaces, shift moves one byte up.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= {W{1'b0}};
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[W-B-1:0], shift_in};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/rsa_byte_frontend.sv
// Byte-stream front/back end for the RSA core: gathers 16 bytes into the
// plaintext, fires one start pulse, waits (bounded) for done, then streams
// the ciphertext back out MSB first.
module rsa_byte_frontend
  import rsa_byte_frontend_pkg::*;
#(
  parameter int NBYTES  = 16,
  parameter int TIMEOUT = 1048576,
  parameter int TW      = 21
) (
  input  logic               clk,
  input  logic               reset,
  rsa_byte_frontend_if.slave bus,
  output logic [RSA_W-1:0]   enc_message,
  output logic               enc_start,
  input  logic               enc_done,
  input  logic [RSA_W-1:0]   enc_c,
  output logic               busy,
  output logic               err_timeout
);

  localparam int              CW     = $clog2(NBYTES);
  localparam logic [CW-1:0]   LAST   = CW'(NBYTES - 1);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     cnt_q;
  logic [TW-1:0]     timer_q;
  logic              in_acc;
  logic              out_acc;
  logic              last_byte;
  logic              ct_load;
  logic              timed_out;
  logic [RSA_W-1:0]  msg_q;
  logic [RSA_W-1:0]  msg_shl;
  logic [RSA_W-1:0]  ct_q;
  logic              unused_bits;

  // Handshakes decode straight from the state register.
  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == SEND);
  assign busy          = (state_q != LOAD);
  assign bus.out_data  = ct_q[RSA_W-1 -: BYTE_W];

  assign in_acc    = bus.in_valid  && (state_q == LOAD);
  assign out_acc   = bus.out_ready && (state_q == SEND);
  assign last_byte = (cnt_q == LAST);
  assign ct_load   = (state_q == WAIT) && enc_done;
  assign timed_out = (state_q == WAIT) && !enc_done && (timer_q == T_LAST);
  assign msg_shl   = {msg_q[RSA_W-BYTE_W-1:0], bus.in_data};

  // The oldest plaintext byte falls off as the block completes and only the
  // top ciphertext byte leaves the serialiser directly.
  assign unused_bits = ^{msg_q[RSA_W-1 -: BYTE_W], ct_q[RSA_W-BYTE_W-1:0]};

  rsa_shift_reg128 #(.W(RSA_W), .B(BYTE_W)) u_plain (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ({RSA_W{1'b0}}),
    .shift     (in_acc),
    .shift_in  (bus.in_data),
    .q         (msg_q)
  );

  rsa_shift_reg128 #(.W(RSA_W), .B(BYTE_W)) u_cipher (
    .clk       (clk),
    .reset     (reset),
    .load      (ct_load),
    .load_data (enc_c),
    .shift     (out_acc),
    .shift_in  ({BYTE_W{1'b0}}),
    .q         (ct_q)
  );

  // Next-state logic; done beats timeout when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (in_acc && last_byte) state_d = START;
        else                     state_d = LOAD;
      end
      START: state_d = WAIT;
      WAIT: begin
        if (enc_done)       state_d = SEND;
        else if (timed_out) state_d = LOAD;
        else                state_d = WAIT;
      end
      SEND: begin
        if (out_acc && last_byte) state_d = LOAD;
        else                      state_d = SEND;
      end
      default: state_d = LOAD;
    endcase
  end

  // State register plus the registered start pulse (high only in START).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOAD;
      enc_start <= 1'b0;
    end else begin
      state_q   <= state_d;
      enc_start <= (state_d == START);
    end
  end

  // Byte counter shared by the assembler and the serialiser.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CW{1'b0}};
    end else if (in_acc || out_acc) begin
      cnt_q <= last_byte ? {CW{1'b0}} : cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else if (ct_load) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  // Wait timer: cleared while starting, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= {TW{1'b0}};
    end else if (state_q == START) begin
      timer_q <= {TW{1'b0}};
    end else if (state_q == WAIT) begin
      timer_q <= timer_q + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      timer_q <= timer_q;
    end
  end

  // Sticky timeout flag, cleared by the next accepted input byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_timeout <= 1'b0;
    end else if (timed_out) begin
      err_timeout <= 1'b1;
    end else if (in_acc) begin
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= err_timeout;
    end
  end

  // Plaintext to the core, frozen from the last accept until the next block.
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_message <= {RSA_W{1'b0}};
    end else if (in_acc && last_byte) begin
      enc_message <= msg_shl;
    end else begin
      enc_message <= enc_message;
    end
  end

endmodule

// File: tb/tb_rsa_byte_frontend.sv
// Directed bench for rsa_byte_frontend with an inline core model.
module tb_rsa_byte_frontend;
  import rsa_byte_frontend_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [RSA_W-1:0] enc_message;
  logic             enc_start;
  logic             enc_done;
  logic [RSA_W-1:0] enc_c;
  logic             busy;
  logic             err_timeout;
  int               tests = 0;
  int               fails = 0;
  int               start_cnt = 0;

  localparam logic [127:0] C1 = 128'hDEADBEEF_00112233_44556677_8899AABB;
  localparam logic [127:0] C2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  rsa_byte_frontend_if bus();

  rsa_byte_frontend #(.NBYTES(16), .TIMEOUT(64), .TW(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .enc_message (enc_message),
    .enc_start   (enc_start),
    .enc_done    (enc_done),
    .enc_c       (enc_c),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Count every cycle the start pulse is seen high.
  always @(posedge clk) begin
    if (enc_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    guard = 0;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_before_accept", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] base, input int maxgap);
    for (int i = 0; i < 16; i++) send_byte(base + 8'(i), int'($urandom_range(0, maxgap)));
  endtask

  task automatic wait_start(input logic [127:0] exp_msg);
    int g;
    g = 0;
    while (enc_start !== 1'b1 && g < 40) begin
      tick();
      g++;
    end
    check("enc_start_seen", enc_start, 1'b1);
    check("enc_start_latency", g, 0);
    check("enc_message", enc_message, exp_msg);
    check("busy_in_start", busy, 1'b1);
  endtask

  task automatic core_done(input int delay, input logic [127:0] c);
    repeat (delay) tick();
    check("enc_start_one_cycle", enc_start, 1'b0);
    enc_done = 1'b1;
    enc_c    = c;
    tick();
    enc_done = 1'b0;
    enc_c    = 128'h0;
    check("out_valid_after_done", bus.out_valid, 1'b1);
  endtask

  task automatic receive(input logic [127:0] c, input bit rnd, input int n);
    int idx;
    int g;
    logic [127:0] sh;
    idx = 0;
    g   = 0;
    sh  = c;
    while (idx < n && g < 400) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check("out_valid", bus.out_valid, 1'b1);
      check("out_data", {120'h0, bus.out_data}, {120'h0, sh[127:120]});
      if (bus.out_ready) begin
        sh = sh << 8;
        idx++;
      end
      tick();
      g++;
    end
    bus.out_ready = 1'b0;
    check("out_byte_count", idx, n);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    enc_done      = 1'b0;
    enc_c         = 128'h0;
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", {120'h0, bus.out_data}, 128'h0);
    check("rst_enc_start", enc_start, 1'b0);
    check("rst_enc_message", enc_message, 128'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    reset = 1'b0;
    tick();

    // 1: back-to-back bytes, core answers 10 cycles after start
    send_block(8'h00, 0);
    wait_start(128'h000102030405060708090A0B0C0D0E0F);
    core_done(10, C1);
    receive(C1, 1'b0, 16);
    check_idle("t1_end");
    check("t1_start_pulses", start_cnt, 1);

    // 2: random input gaps and random out_ready
    send_block(8'h10, 3);
    wait_start(128'h101112131415161718191A1B1C1D1E1F);
    core_done(10, C1);
    receive(C1, 1'b1, 16);
    check_idle("t2_end");

    // 3: core never answers; 64 WAIT cycles then timeout
    send_block(8'h20, 0);
    wait_start(128'h202122232425262728292A2B2C2D2E2F);
    for (int k = 1; k <= 64; k++) begin
      tick();
      check("t3_err_low", err_timeout, 1'b0);
      check("t3_no_out", bus.out_valid, 1'b0);
    end
    tick();
    check("t3_err_set", err_timeout, 1'b1);
    check_idle("t3_after_timeout");
    tick();
    check("t3_err_sticky", err_timeout, 1'b1);
    send_byte(8'h30, 0);
    check("t3_err_cleared", err_timeout, 1'b0);

    // 4: in_valid held with 0xAA during WAIT is not absorbed
    for (int i = 1; i < 16; i++) send_byte(8'h30 + 8'(i), 0);
    wait_start(128'h303132333435363738393A3B3C3D3E3F);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_in_ready_low", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    core_done(0, C2);
    receive(C2, 1'b0, 16);
    check_idle("t4_end");

    // 6: stray enc_done in LOAD after 3 bytes is ignored
    for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i), 0);
    enc_done = 1'b1;
    enc_c    = C2;
    tick();
    enc_done = 1'b0;
    enc_c    = 128'h0;
    check_idle("t6_stray_done");
    for (int i = 3; i < 16; i++) send_byte(8'h40 + 8'(i), 0);
    wait_start(128'h404142434445464748494A4B4C4D4E4F);
    core_done(10, C1);
    receive(C1, 1'b0, 16);
    check_idle("t6_end");

    // 5: reset after the 5th output byte, then a fresh block
    send_block(8'h50, 0);
    wait_start(128'h505152535455565758595A5B5C5D5E5F);
    core_done(10, C2);
    receive(C2, 1'b0, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("t5_after_reset");
    check("t5_out_data", {120'h0, bus.out_data}, 128'h0);
    check("t5_enc_message", enc_message, 128'h0);
    tick();
    check("t5_no_emit", bus.out_valid, 1'b0);
    send_block(8'h60, 0);
    wait_start(128'h606162636465666768696A6B6C6D6E6F);
    core_done(10, C1);
    receive(C1, 1'b0, 16);
    check_idle("t5_end");
    check("total_start_pulses", start_cnt, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
